// File: rtl/spi_sva_pkg.sv
// Shared SPI definitions for the slave core and its protocol checker.
// Holds the FSM state type and the CPOL/CPHA edge classification.
package spi_sva_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_e;

    // The edge that captures data: rise when CPOL==CPHA, fall otherwise.
    function automatic logic is_sampling_edge(
        input logic cpol,
        input logic cpha,
        input logic rise,
        input logic fall
    );
        return (cpol == cpha) ? rise : fall;
    endfunction

    // The edge that launches data: the opposite of the sampling edge.
    function automatic logic is_change_edge(
        input logic cpol,
        input logic cpha,
        input logic rise,
        input logic fall
    );
        return (cpol == cpha) ? fall : rise;
    endfunction

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for one asynchronous SPI pin.
// The reset value is a parameter so each pin resets to its idle level.
module spi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave datapath: oversampled pins, RX shifter with valid pulse,
// TX shifter fed from a one-deep valid/ready holding register.
module spi_slave_core
    import spi_sva_pkg::*;
#(
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0,
    parameter int   DATA_WIDTH = 8,
    parameter logic MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    // Bit presented first on the wire for a given word.
    function automatic logic first_bit(input logic [W-1:0] w);
        return MSB_FIRST ? w[W-1] : w[0];
    endfunction

    // Word with its first-on-wire bit consumed.
    function automatic logic [W-1:0] drop_bit(input logic [W-1:0] w);
        return MSB_FIRST ? {w[W-2:0], 1'b0} : {1'b0, w[W-1:1]};
    endfunction

    logic sclk_s, cs_s, mosi_s;
    logic sclk_prev_q, cs_prev_q;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic samp_edge, chg_edge;

    spi_slv_state_e state_q, state_d;

    logic [W-1:0]  tx_sh_q, tx_sh_d;
    logic [W-1:0]  rx_sh_q, rx_sh_d;
    logic [W-1:0]  rx_next;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          empty_q, empty_d;
    logic          miso_q, miso_d, miso_nx;
    logic          miso_oe_q, miso_oe_d;
    logic [W-1:0]  rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_underrun_q, tx_underrun_d;
    logic          frame_abort_q, frame_abort_d;
    logic          load;
    logic [W-1:0]  ld_word;

    spi_sync2 #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (sclk),
        .q_o     (sclk_s)
    );

    spi_sync2 #(.RST_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (cs_n),
        .q_o     (cs_s)
    );

    spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (mosi),
        .q_o     (mosi_s)
    );

    // Previous synchronized levels, used for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign samp_edge = is_sampling_edge(CPOL, CPHA, sclk_rise, sclk_fall);
    assign chg_edge  = is_change_edge(CPOL, CPHA, sclk_rise, sclk_fall);

    assign rx_next = MSB_FIRST ? {rx_sh_q[W-2:0], mosi_s}
                               : {mosi_s, rx_sh_q[W-1:1]};
    assign ld_word = empty_q ? '0 : hold_q;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: chip select framing only.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: drive enable follows ACTIVE, MISO held low otherwise.
    always_comb begin
        miso_oe_d = (state_d == ACTIVE);
        miso_d    = miso_oe_d ? miso_nx : 1'b0;
    end

    // Shift datapath: frame start, sampling, launching and abort.
    always_comb begin
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        bit_cnt_d     = bit_cnt_q;
        miso_nx       = miso_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_abort_d = 1'b0;
        load          = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                load      = 1'b1;
                bit_cnt_d = '0;
                rx_sh_d   = '0;
                if (CPHA) begin
                    tx_sh_d = ld_word;
                    miso_nx = 1'b0;
                end else begin
                    tx_sh_d = drop_bit(ld_word);
                    miso_nx = first_bit(ld_word);
                end
            end
        end else if (cs_rise) begin
            frame_abort_d = (bit_cnt_q != '0);
            bit_cnt_d     = '0;
        end else if (samp_edge) begin
            rx_sh_d = rx_next;
            if (bit_cnt_q == LAST) begin
                rx_data_d  = rx_next;
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
                load       = 1'b1;
                tx_sh_d    = ld_word;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (chg_edge) begin
            miso_nx = first_bit(tx_sh_q);
            tx_sh_d = drop_bit(tx_sh_q);
        end
    end

    // Holding register: a shift load empties it, a handshake refills it.
    always_comb begin
        hold_d        = hold_q;
        empty_d       = empty_q;
        tx_underrun_d = load & empty_q;
        if (load) begin
            empty_d = 1'b1;
        end
        if (tx_valid && empty_q) begin
            hold_d  = tx_data;
            empty_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sh_q       <= '0;
            rx_sh_q       <= '0;
            bit_cnt_q     <= '0;
            hold_q        <= '0;
            empty_q       <= 1'b1;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            tx_sh_q       <= tx_sh_d;
            rx_sh_q       <= rx_sh_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_q        <= hold_d;
            empty_q       <= empty_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = empty_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: one instance per SPI mode, a bus-functional
// master, and RX/TX scoreboards fed as stimulus is driven.
module tb_spi_slave_core;

    localparam int H = 4;
    localparam logic [7:0] PAD = 8'hC3;

    logic clk = 1'b0;
    logic reset_n;

    logic       sclk     [4];
    logic       cs_n     [4];
    logic       mosi     [4];
    logic       miso     [4];
    logic       miso_oe  [4];
    logic [7:0] tx_data  [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic [7:0] rx_data  [4];
    logic       rx_valid [4];
    logic       und      [4];
    logic       abt      [4];

    int checks   = 0;
    int failures = 0;
    int und_cnt [4];
    int abt_cnt [4];

    logic [10:0] rxq [$];
    logic [9:0]  txq [$];
    logic [10:0] rx_e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic POL = (g >= 2);
        localparam logic PHA = (g % 2 == 1);
        localparam logic MSB = (g < 2);
        spi_slave_core #(
            .CPOL       (POL),
            .CPHA       (PHA),
            .DATA_WIDTH (8),
            .MSB_FIRST  (MSB)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .sclk        (sclk[g]),
            .cs_n        (cs_n[g]),
            .mosi        (mosi[g]),
            .miso        (miso[g]),
            .miso_oe     (miso_oe[g]),
            .tx_data     (tx_data[g]),
            .tx_valid    (tx_valid[g]),
            .tx_ready    (tx_ready[g]),
            .rx_data     (rx_data[g]),
            .rx_valid    (rx_valid[g]),
            .tx_underrun (und[g]),
            .frame_abort (abt[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pulse counters, idle MISO level, RX scoreboard.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            und_cnt[g] += int'(und[g]);
            abt_cnt[g] += int'(abt[g]);
            if (!miso_oe[g]) check("miso_idle", 32'(miso[g]), 32'd0);
            if (rx_valid[g]) begin
                rx_e = 11'h0;
                if (rxq.size() != 0) rx_e = rxq.pop_front();
                check("rx_word", {21'd0, 1'b1, 2'(g), rx_data[g]},
                      {21'd0, rx_e});
            end
        end
    end

    task automatic push_tx(input int m, input logic [7:0] w);
        int n;
        n = 0;
        while (!tx_ready[m] && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", 32'(tx_ready[m]), 32'd1);
        tx_data[m]  = w;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
        txq.push_back({2'(m), w});
    endtask

    task automatic xfer(input int m, input logic [7:0] w, input int nbits,
                        output logic [7:0] r);
        logic cpol, cpha, msb;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        msb  = (m < 2);
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = msb ? 7 - i : i;
            if (!cpha) begin
                mosi[m] = w[b];
                repeat (H) @(negedge clk);
                sclk[m] = ~cpol;
                r[b] = miso[m];
                repeat (H) @(negedge clk);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = w[b];
                repeat (H) @(negedge clk);
                sclk[m] = cpol;
                r[b] = miso[m];
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic frame(input int m, input int n, input logic [31:0] mo,
                         input logic [31:0] ti, input bit starve);
        logic [7:0] r;
        logic [9:0] e;
        push_tx(m, ti[7:0]);
        check("tx_ready_full", 32'(tx_ready[m]), 32'd0);
        cs_n[m] = 1'b0;
        repeat (6) @(negedge clk);
        check("tx_ready_rise", 32'(tx_ready[m]), 32'd1);
        check("miso_oe_on", 32'(miso_oe[m]), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (starve && k == 0) txq.push_back({2'(m), 8'h00});
            else push_tx(m, ti[8*(k+1) +: 8]);
            rxq.push_back({1'b1, 2'(m), mo[8*k +: 8]});
            xfer(m, mo[8*k +: 8], 8, r);
            e = 10'h3FF;
            if (txq.size() != 0) e = txq.pop_front();
            check("miso_word", 32'({2'(m), r}), 32'(e));
        end
        repeat (H) @(negedge clk);
        cs_n[m] = 1'b1;
        repeat (6) @(negedge clk);
        check("miso_oe_off", 32'(miso_oe[m]), 32'd0);
        if (txq.size() != 0) void'(txq.pop_front());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u, a;
        logic [7:0] r;
        reset_n = 1'b0;
        for (int m = 0; m < 4; m++) begin
            sclk[m] = (m >= 2);
            cs_n[m] = 1'b1;
            mosi[m] = 1'b0;
            tx_data[m] = '0;
            tx_valid[m] = 1'b0;
            und_cnt[m] = 0;
            abt_cnt[m] = 0;
        end
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check("rst_tx_ready", 32'(tx_ready[m]), 32'd1);
            check("rst_oe", 32'(miso_oe[m]), 32'd0);
            check("rst_rx_data", 32'(rx_data[m]), 32'd0);
            check("rst_rx_valid", 32'(rx_valid[m]), 32'd0);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        u = und_cnt[0];
        frame(0, 1, 32'h0000_003C, {16'h0, PAD, 8'hA5}, 1'b0);
        check("m0_rx_data", 32'(rx_data[0]), 32'h3C);
        check("m0_no_und", 32'(und_cnt[0] - u), 32'd0);

        u = und_cnt[3];
        frame(3, 2, 32'h0000_0FF0, {8'h0, PAD, 16'h8001}, 1'b0);
        check("m3_rx_data", 32'(rx_data[3]), 32'h0F);
        check("m3_no_und", 32'(und_cnt[3] - u), 32'd0);

        u = und_cnt[0];
        frame(0, 2, 32'h0000_5AC3, {8'h0, PAD, 16'h0077}, 1'b1);
        check("und_rx_data", 32'(rx_data[0]), 32'h5A);
        check("und_pulse", 32'(und_cnt[0] - u), 32'd1);

        a = abt_cnt[1];
        push_tx(1, 8'h99);
        cs_n[1] = 1'b0;
        repeat (6) @(negedge clk);
        xfer(1, 8'hB6, 5, r);
        cs_n[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_oe", 32'(miso_oe[1]), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_pulse", 32'(abt_cnt[1] - a), 32'd1);
        check("abort_rx_data", 32'(rx_data[1]), 32'd0);
        if (txq.size() != 0) void'(txq.pop_front());
        frame(1, 1, 32'h0000_0055, {16'h0, PAD, 8'h3A}, 1'b0);
        check("after_abort_rx", 32'(rx_data[1]), 32'h55);

        push_tx(0, 8'h3C);
        cs_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        push_tx(0, 8'h11);
        check("pre_rst_ready", 32'(tx_ready[0]), 32'd0);
        xfer(0, 8'hF0, 4, r);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_miso", 32'(miso[0]), 32'd0);
        check("arst_oe", 32'(miso_oe[0]), 32'd0);
        check("arst_ready", 32'(tx_ready[0]), 32'd1);
        check("arst_rx_data", 32'(rx_data[0]), 32'd0);
        check("arst_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("arst_und", 32'(und[0]), 32'd0);
        check("arst_abort", 32'(abt[0]), 32'd0);
        cs_n[0] = 1'b1;
        sclk[0] = 1'b0;
        txq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_ready", 32'(tx_ready[0]), 32'd1);
        check("post_rst_oe", 32'(miso_oe[0]), 32'd0);

        for (int m = 0; m < 4; m++) begin
            u = und_cnt[m];
            a = abt_cnt[m];
            for (int f = 0; f < 12; f++) begin
                int n;
                n = int'($urandom_range(1, 3));
                frame(m, n, $urandom, $urandom, 1'b0);
            end
            check("rand_no_und", 32'(und_cnt[m] - u), 32'd0);
            check("rand_no_abort", 32'(abt_cnt[m] - a), 32'd0);
        end

        repeat (10) @(negedge clk);
        check("rxq_drained", 32'(rxq.size()), 32'd0);
        check("txq_drained", 32'(txq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
